// File: rtl/liteeth_sram_fifo_pkg.sv
// Shared defaults and width helpers for the SRAM-backed stream FIFO controller.
package liteeth_sram_fifo_pkg;

  localparam int unsigned DEF_BITS       = 12;
  localparam int unsigned DEF_WORD_DEPTH = 128;
  localparam int unsigned DEF_ADDR_WIDTH = 7;

  // Level must also count the two output-buffer entries and one read in flight.
  localparam int unsigned LEVEL_EXTRA     = 2;
  localparam int unsigned DEF_LEVEL_WIDTH = DEF_ADDR_WIDTH + LEVEL_EXTRA;

  function automatic int unsigned level_width(input int unsigned addr_width);
    return addr_width + LEVEL_EXTRA;
  endfunction

endpackage

// File: rtl/liteeth_sram_fifo_outbuf.sv
// Two-entry output skid buffer fed by the SRAM read port; head entry drives the stream.
module liteeth_sram_fifo_outbuf
  import liteeth_sram_fifo_pkg::*;
#(
  parameter int unsigned BITS = DEF_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fill,
  input  logic [BITS-1:0] fill_data,
  input  logic            pop,
  output logic            out_valid,
  output logic [BITS-1:0] out_data,
  output logic [1:0]      occ
);

  logic [BITS-1:0] head_q, head_d;
  logic [BITS-1:0] tail_q, tail_d;
  logic [1:0]      occ_q, occ_d;
  logic            valid_q;

  // Next-state: a fill arriving with a pop lands behind whatever is still queued.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case (occ_q)
      2'd0: begin
        if (fill) begin
          head_d = fill_data;
          occ_d  = 2'd1;
        end
      end
      2'd1: begin
        case ({fill, pop})
          2'b10: begin
            tail_d = fill_data;
            occ_d  = 2'd2;
          end
          2'b01: occ_d = 2'd0;
          2'b11: head_d = fill_data;
          default: ;
        endcase
      end
      default: begin
        if (pop) begin
          head_d = tail_q;
          if (fill) tail_d = fill_data;
          else      occ_d  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      valid_q <= (occ_d != 2'd0);
    end
  end

  assign out_valid = valid_q;
  assign out_data  = head_q;
  assign occ       = occ_q;

endmodule

// File: rtl/liteeth_sram_fifo_ctrl.sv
// Stream FIFO controller around an external 1R1W SRAM with 1-cycle read latency.
// Optional almost_full/almost_empty watermarks under LITEETH_SRAM_FIFO_WATERMARK_EN.
module liteeth_sram_fifo_ctrl
  import liteeth_sram_fifo_pkg::*;
#(
  parameter int unsigned BITS       = DEF_BITS,
  parameter int unsigned WORD_DEPTH = DEF_WORD_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
`ifdef LITEETH_SRAM_FIFO_WATERMARK_EN
  ,
  parameter int unsigned AFULL_TH   = 120,
  parameter int unsigned AEMPTY_TH  = 4
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS-1:0]       in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BITS-1:0]       out_data,
  output logic [ADDR_WIDTH+1:0] level,
`ifdef LITEETH_SRAM_FIFO_WATERMARK_EN
  output logic                  almost_full,
  output logic                  almost_empty,
`endif
  output logic                  rw0_clk,
  output logic                  rw0_ce_in,
  output logic                  rw0_we_in,
  output logic [ADDR_WIDTH-1:0] rw0_addr_in,
  output logic [BITS-1:0]       rw0_wd_in,
  output logic                  r0_clk,
  output logic                  r0_ce_in,
  output logic [ADDR_WIDTH-1:0] r0_addr_in,
  input  logic [BITS-1:0]       r0_rd_out
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam int unsigned LW = level_width(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         mem_count_q, mem_count_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  inflight_q;
  logic                  in_ready_q;
  logic [1:0]            buf_occ;
  logic                  push_c, pop_c, rd_issue_c;

  assign push_c = in_valid && in_ready_q;
  assign pop_c  = out_valid && out_ready;
  // Prefetch only while the buffer, counting the read in flight, has a free slot after this pop.
  assign rd_issue_c = (mem_count_q != '0) &&
                      ((3'(buf_occ) + 3'(inflight_q)) < (3'd2 + 3'(pop_c)));

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_count_d = mem_count_q;
    level_d     = level_q;
    if (push_c)
      wr_ptr_d = (wr_ptr_q == ADDR_WIDTH'(WORD_DEPTH - 1)) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_issue_c)
      rd_ptr_d = (rd_ptr_q == ADDR_WIDTH'(WORD_DEPTH - 1)) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
    case ({push_c, rd_issue_c})
      2'b10:   mem_count_d = mem_count_q + CW'(1);
      2'b01:   mem_count_d = mem_count_q - CW'(1);
      default: ;
    endcase
    case ({push_c, pop_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: ;
    endcase
  end

  // in_ready stays low through reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_count_q <= '0;
      level_q     <= '0;
      inflight_q  <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_count_q <= mem_count_d;
      level_q     <= level_d;
      inflight_q  <= rd_issue_c;
      in_ready_q  <= (mem_count_d < CW'(WORD_DEPTH));
    end
  end

  liteeth_sram_fifo_outbuf #(
    .BITS (BITS)
  ) u_outbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .fill      (inflight_q),
    .fill_data (r0_rd_out),
    .pop       (pop_c),
    .out_valid (out_valid),
    .out_data  (out_data),
    .occ       (buf_occ)
  );

  assign in_ready    = in_ready_q;
  assign level       = level_q;
  assign rw0_clk     = clk;
  assign rw0_ce_in   = push_c;
  assign rw0_we_in   = push_c;
  assign rw0_addr_in = wr_ptr_q;
  assign rw0_wd_in   = in_data;
  assign r0_clk      = clk;
  assign r0_ce_in    = rd_issue_c;
  assign r0_addr_in  = rd_ptr_q;

`ifdef LITEETH_SRAM_FIFO_WATERMARK_EN
  logic almost_full_q, almost_empty_q;

  // Flags track the level being loaded this edge so they align with the level output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      almost_full_q  <= (level_d >= LW'(AFULL_TH));
      almost_empty_q <= (level_d <= LW'(AEMPTY_TH));
    end
  end

  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
`endif

endmodule

// File: tb/tb_liteeth_sram_fifo_ctrl.sv
// Self-checking bench: SRAM model, negedge monitor with scoreboard, one task per scenario.
module tb_liteeth_sram_fifo_ctrl;
  import liteeth_sram_fifo_pkg::*;

  localparam int unsigned BITS  = DEF_BITS;
  localparam int unsigned DEPTH = DEF_WORD_DEPTH;
  localparam int unsigned AW    = DEF_ADDR_WIDTH;
  localparam int unsigned LW    = DEF_LEVEL_WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [BITS-1:0] in_data, out_data, rw0_wd_in, r0_rd_out;
  logic [LW-1:0] level;
  logic rw0_clk, rw0_ce_in, rw0_we_in, r0_clk, r0_ce_in;
  logic [AW-1:0] rw0_addr_in, r0_addr_in;
`ifdef LITEETH_SRAM_FIFO_WATERMARK_EN
  logic almost_full, almost_empty;
`endif

  always #5 clk = ~clk;

  liteeth_sram_fifo_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .level        (level),
`ifdef LITEETH_SRAM_FIFO_WATERMARK_EN
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`endif
    .rw0_clk      (rw0_clk),
    .rw0_ce_in    (rw0_ce_in),
    .rw0_we_in    (rw0_we_in),
    .rw0_addr_in  (rw0_addr_in),
    .rw0_wd_in    (rw0_wd_in),
    .r0_clk       (r0_clk),
    .r0_ce_in     (r0_ce_in),
    .r0_addr_in   (r0_addr_in),
    .r0_rd_out    (r0_rd_out)
  );

  // SRAM macro model with one-cycle registered read.
  logic [BITS-1:0] sram [DEPTH];
  always @(posedge clk) begin
    if (rw0_ce_in && rw0_we_in) sram[rw0_addr_in] <= rw0_wd_in;
    if (r0_ce_in) r0_rd_out <= sram[r0_addr_in];
  end

  int tests_run = 0;
  int fails = 0;
  logic [BITS-1:0] exp_q[$];
  int mdl_level = 0, seen_level = 0, mdl_wr = 0, mdl_rd = 0;
  int acc_cnt = 0, pop_cnt = 0, wrap_cnt = 0, stall_cnt = 0;
  int prev_wr_addr = 0;
  logic stall_prev = 1'b0;
  logic [BITS-1:0] stall_data = '0;

  // Monitor: inputs only change just after posedge, so negedge shows what the next edge commits.
  always @(negedge clk) begin
    logic acc, pop;
    logic [BITS-1:0] exp;
    if (!rst_n) begin
      exp_q.delete();
      mdl_level = 0; seen_level = 0; mdl_wr = 0; mdl_rd = 0; stall_prev = 1'b0;
      tests_run++;
      if (out_valid !== 1'b0 || level !== '0 || rw0_ce_in !== 1'b0 || rw0_we_in !== 1'b0 || r0_ce_in !== 1'b0) begin
        fails++;
        $display("FAIL in_reset_outputs: got ov=%b lvl=%0d ce=%b we=%b rce=%b expected all 0",
                 out_valid, level, rw0_ce_in, rw0_we_in, r0_ce_in);
      end
    end else begin
      seen_level = mdl_level;
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      tests_run++;
      if (level !== LW'(mdl_level)) begin
        fails++; $display("FAIL level: got %0d expected %0d", level, mdl_level);
      end
      tests_run++;
      if (rw0_ce_in !== acc || rw0_we_in !== acc) begin
        fails++; $display("FAIL write_enable: got ce=%b we=%b expected %b", rw0_ce_in, rw0_we_in, acc);
      end
      if (acc) begin
        tests_run++;
        if (rw0_addr_in !== AW'(mdl_wr) || rw0_wd_in !== in_data) begin
          fails++;
          $display("FAIL write_port: got addr=%0d data=%h expected addr=%0d data=%h",
                   rw0_addr_in, rw0_wd_in, mdl_wr, in_data);
        end
        if (rw0_addr_in == '0 && prev_wr_addr == int'(DEPTH - 1)) wrap_cnt++;
        prev_wr_addr = int'(rw0_addr_in);
        exp_q.push_back(in_data);
        mdl_wr = (mdl_wr + 1) % DEPTH;
        mdl_level++;
        acc_cnt++;
      end
      if (r0_ce_in) begin
        tests_run++;
        if (r0_addr_in !== AW'(mdl_rd) || (rw0_ce_in && rw0_addr_in == r0_addr_in)) begin
          fails++;
          $display("FAIL read_port: got addr=%0d wr_ce=%b wr_addr=%0d expected addr=%0d distinct from write",
                   r0_addr_in, rw0_ce_in, rw0_addr_in, mdl_rd);
        end
        mdl_rd = (mdl_rd + 1) % DEPTH;
      end
      if (stall_prev) begin
        tests_run++;
        stall_cnt++;
        if (out_valid !== 1'b1 || out_data !== stall_data) begin
          fails++;
          $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, stall_data);
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      if (pop) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL scoreboard_extra: got %h expected no output", out_data);
        end else begin
          exp = exp_q.pop_front();
          if (out_data !== exp) begin
            fails++; $display("FAIL scoreboard_data: got %h expected %h", out_data, exp);
          end
        end
        mdl_level--;
        pop_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic drain();
    logic done = 1'b0;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 400; c++) begin
      mid();
      if (seen_level == 0 && exp_q.size() == 0) begin done = 1'b1; break; end
      step();
    end
    tests_run++;
    if (!done) begin
      fails++; $display("FAIL drain_timeout: got level %0d expected 0 within 400 cycles", seen_level);
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) step();
    tests_run++;
    if (out_valid !== 1'b0 || level !== '0 || r0_ce_in !== 1'b0) begin
      fails++; $display("FAIL reset_state: got ov=%b lvl=%0d rce=%b expected 0", out_valid, level, r0_ce_in);
    end
`ifdef LITEETH_SRAM_FIFO_WATERMARK_EN
    tests_run++;
    if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin
      fails++; $display("FAIL reset_watermark: got af=%b ae=%b expected af=0 ae=1", almost_full, almost_empty);
    end
`endif
    @(posedge clk); #2 rst_n = 1'b1;
    step(); mid();
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || level !== '0) begin
      fails++; $display("FAIL post_reset: got rdy=%b ov=%b lvl=%0d expected rdy=1 ov=0 lvl=0", in_ready, out_valid, level);
    end
  endtask

  task automatic test_single();
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 12'hABC;
    mid();
    tests_run++;
    if (rw0_ce_in !== 1'b1 || rw0_addr_in !== AW'(0) || rw0_wd_in !== 12'hABC || rw0_clk !== 1'b0 || r0_clk !== 1'b0) begin
      fails++; $display("FAIL single_write: got ce=%b addr=%0d data=%h expected ce=1 addr=0 data=abc",
                        rw0_ce_in, rw0_addr_in, rw0_wd_in);
    end
    step();
    in_valid = 1'b0;
    mid();
    tests_run++;
    if (r0_ce_in !== 1'b1 || r0_addr_in !== AW'(0) || out_valid !== 1'b0) begin
      fails++; $display("FAIL single_read_issue: got rce=%b raddr=%0d ov=%b expected rce=1 raddr=0 ov=0",
                        r0_ce_in, r0_addr_in, out_valid);
    end
    step(); mid();
    tests_run++;
    if (out_valid !== 1'b0 || r0_ce_in !== 1'b0) begin
      fails++; $display("FAIL single_inflight: got ov=%b rce=%b expected 0 0", out_valid, r0_ce_in);
    end
    step(); mid();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 12'hABC || level !== LW'(1)) begin
      fails++; $display("FAIL single_output: got ov=%b data=%h lvl=%0d expected ov=1 data=abc lvl=1",
                        out_valid, out_data, level);
    end
    drain();
  endtask

  task automatic test_fill();
    int acc = 0;
    step();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 140; c++) begin
      in_data = BITS'(32'h100 + acc);
      mid();
      if (in_valid && in_ready) acc++;
      step();
    end
    in_valid = 1'b0;
    mid();
    tests_run++;
    if (acc != 130 || level !== LW'(130) || in_ready !== 1'b0) begin
      fails++; $display("FAIL fill_full: got accepted=%0d lvl=%0d rdy=%b expected 130 130 0", acc, level, in_ready);
    end
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 12'h100) begin
      fails++; $display("FAIL fill_head: got ov=%b data=%h expected ov=1 data=100", out_valid, out_data);
    end
    drain();
  endtask

  task automatic test_stream();
    int idx = 0, steady = 0;
    int p0 = pop_cnt, w0 = wrap_cnt;
    step();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 400 && idx < 300; c++) begin
      in_data = BITS'(idx);
      mid();
      if (in_valid && in_ready) idx++;
      if (c >= 10 && c < 290 && out_valid && out_ready && in_ready) steady++;
      step();
    end
    in_valid = 1'b0;
    tests_run++;
    if (idx != 300 || steady != 280) begin
      fails++; $display("FAIL stream_rate: got pushed=%0d steady=%0d expected 300 280", idx, steady);
    end
    drain();
    tests_run++;
    if (pop_cnt - p0 != 300 || wrap_cnt - w0 < 2) begin
      fails++; $display("FAIL stream_total: got popped=%0d wraps=%0d expected 300 >=2", pop_cnt - p0, wrap_cnt - w0);
    end
  endtask

  task automatic test_stall();
    int idx = 0;
    int p0 = pop_cnt, s0 = stall_cnt;
    step();
    in_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      in_data = BITS'(32'h200 + idx);
      out_ready = (c % 2 == 0);
      mid();
      if (in_valid && in_ready) idx++;
      step();
    end
    in_valid = 1'b0;
    drain();
    tests_run++;
    if (pop_cnt - p0 != idx || stall_cnt - s0 < 10) begin
      fails++; $display("FAIL stall_total: got popped=%0d stalls=%0d expected %0d >=10", pop_cnt - p0, stall_cnt - s0, idx);
    end
  endtask

  task automatic test_reset_mid();
    int idx = 0;
    logic found = 1'b0;
    step();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (idx == 50) break;
      in_data = BITS'(32'h300 + idx);
      mid();
      if (in_valid && in_ready) idx++;
      step();
    end
    in_valid = 1'b0;
    mid();
    tests_run++;
    if (level !== LW'(50)) begin
      fails++; $display("FAIL mid_level: got %0d expected 50", level);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || level !== '0 || r0_ce_in !== 1'b0) begin
      fails++; $display("FAIL async_reset: got ov=%b lvl=%0d rce=%b expected 0", out_valid, level, r0_ce_in);
    end
    step(); step();
    @(posedge clk); #2 rst_n = 1'b1;
    step();
    in_valid = 1'b1; in_data = 12'h123;
    mid();
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      mid();
      if (out_valid) begin found = 1'b1; break; end
      step();
    end
    tests_run++;
    if (!found || out_data !== 12'h123) begin
      fails++; $display("FAIL after_reset_data: got valid=%b data=%h expected valid=1 data=123", found, out_data);
    end
    drain();
  endtask

`ifdef LITEETH_SRAM_FIFO_WATERMARK_EN
  task automatic test_watermark();
    int idx = 0;
    logic hit_af = 1'b0, hit_ae = 1'b0;
    step();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      in_data = BITS'(idx);
      mid();
      tests_run++;
      if (almost_full !== (seen_level >= 120) || almost_empty !== (seen_level <= 4)) begin
        fails++; $display("FAIL wm_fill: got af=%b ae=%b at level %0d", almost_full, almost_empty, seen_level);
      end
      if (seen_level == 120) hit_af = 1'b1;
      if (in_valid && in_ready) idx++;
      if (seen_level >= 125) break;
      step();
    end
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      mid();
      tests_run++;
      if (almost_full !== (seen_level >= 120) || almost_empty !== (seen_level <= 4)) begin
        fails++; $display("FAIL wm_drain: got af=%b ae=%b at level %0d", almost_full, almost_empty, seen_level);
      end
      if (seen_level == 4) hit_ae = 1'b1;
      if (seen_level == 0) break;
      step();
    end
    tests_run++;
    if (!hit_af || !hit_ae) begin
      fails++; $display("FAIL wm_coverage: got hit_af=%b hit_ae=%b expected 1 1", hit_af, hit_ae);
    end
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_stall();
    test_reset_mid();
`ifdef LITEETH_SRAM_FIFO_WATERMARK_EN
    test_watermark();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion before 200000");
    $fatal(1);
  end

endmodule
